// File: rtl/gs_pkg.sv
// Shared types and helpers for the Goldschmidt divider sequencer.
// Product rounding is selected by GOLDSCHMIDT_ROUND_EN.
package gs_pkg;

  localparam int WIDTH = 24;
  localparam int FRAC  = 23;

  localparam logic [WIDTH-1:0] ONE  = 24'h800000;
  localparam logic [WIDTH-1:0] QERR = 24'hFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    MUL_N,
    MUL_D,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    TAG_N,
    TAG_D
  } tag_t;

  // Q2.46 product back to Q1.23; bit 47 is zero by operand range
  function automatic logic [WIDTH-1:0] prod_slice(
    input logic [2*WIDTH-1:0] p
  );
`ifdef GOLDSCHMIDT_ROUND_EN
    return WIDTH'(p >> FRAC) + WIDTH'(p[FRAC-1]);
`else
    return WIDTH'(p >> FRAC);
`endif
  endfunction

endpackage

// File: rtl/goldschmidt_ctrl_tag_pipe.sv
// Tracks which register each in-flight multiplier product belongs to.
// Depth equals the external multiplier latency.
module gs_tag_pipe
  import gs_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic push_valid,
  input  tag_t push_tag,
  output logic capture_n,
  output logic capture_d
);

  logic [MUL_LAT-1:0] vld;
  tag_t               tg [MUL_LAT];

  // shift valid/tag alongside the multiplier pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < MUL_LAT; i++)
        tg[i] <= TAG_N;
    end else begin
      vld[0] <= push_valid;
      tg[0]  <= push_tag;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld[i] <= vld[i-1];
        tg[i]  <= tg[i-1];
      end
    end
  end

  // the emerging tag steers the product on this edge
  always_comb begin
    capture_n = vld[MUL_LAT-1] && (tg[MUL_LAT-1] == TAG_N);
    capture_d = vld[MUL_LAT-1] && (tg[MUL_LAT-1] == TAG_D);
  end

endmodule

// File: rtl/goldschmidt_ctrl.sv
// Goldschmidt division sequencer sharing one external multiplier.
// Define GOLDSCHMIDT_ROUND_EN to round captured products half up.
module goldschmidt_ctrl #(
  parameter int WIDTH   = 24,
  parameter int ITERS   = 5,
  parameter int MUL_LAT = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   n_in,
  input  logic [WIDTH-1:0]   d_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   q,
  output logic               err,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p
);

  import gs_pkg::*;

  localparam int IW = $clog2(ITERS + 1);

  state_t          state, state_nx;
  logic [WIDTH-1:0] n_r, d_r, f, a_r, b_r, q_r;
  logic [IW-1:0]   iter;
  logic            err_r, bad, last;
  logic            push_v, cap_n, cap_d;
  tag_t            push_t;

  gs_tag_pipe #(
    .MUL_LAT(MUL_LAT)
  ) u_tags (
    .clock     (clock),
    .reset     (reset),
    .push_valid(push_v),
    .push_tag  (push_t),
    .capture_n (cap_n),
    .capture_d (cap_d)
  );

  // range check, 2-D factor and final-iteration flag
  always_comb begin
    bad  = (d_in[WIDTH-1 -: 2] != 2'b01) || n_in[WIDTH-1];
    f    = '0 - d_r;
    last = (iter == IW'(ITERS - 1));
  end

  // next state, operand mux and tag push
  always_comb begin
    state_nx = state;
    mul_a    = a_r;
    mul_b    = b_r;
    push_v   = 1'b0;
    push_t   = TAG_N;
    unique case (state)
      IDLE: if (start) state_nx = bad ? DONE : MUL_N;
      MUL_N: begin
        mul_a    = n_r;
        mul_b    = f;
        push_v   = 1'b1;
        push_t   = TAG_N;
        state_nx = MUL_D;
      end
      MUL_D: begin
        mul_a    = d_r;
        mul_b    = f;
        push_v   = 1'b1;
        push_t   = TAG_D;
        state_nx = WAIT;
      end
      WAIT: if (cap_d) state_nx = last ? DONE : MUL_N;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state, operand hold, product capture and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      n_r   <= '0;
      d_r   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      q_r   <= '0;
      err_r <= 1'b0;
      iter  <= '0;
    end else begin
      state <= state_nx;
      a_r   <= mul_a;
      b_r   <= mul_b;
      if (state == IDLE && start) begin
        n_r  <= n_in;
        d_r  <= d_in;
        iter <= '0;
        if (bad) begin
          q_r   <= QERR;
          err_r <= 1'b1;
        end
      end
      if (cap_n) n_r <= prod_slice(mul_p);
      if (cap_d) begin
        d_r  <= prod_slice(mul_p);
        iter <= iter + 1'b1;
      end
      if (state == WAIT && cap_d && last) begin
        q_r   <= n_r;
        err_r <= 1'b0;
      end
    end
  end

  assign busy = (state == MUL_N) || (state == MUL_D)
             || (state == WAIT);
  assign done = (state == DONE);
  assign q    = q_r;
  assign err  = err_r;

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Directed bench for goldschmidt_ctrl at multiplier latency 1 and 3.
// Both instances share stimulus; each has its own multiplier model.
module tb_goldschmidt_ctrl;

`ifdef GOLDSCHMIDT_ROUND_EN
  localparam logic [23:0] QA = 24'h800000;
`else
  localparam logic [23:0] QA = 24'h7FFFFF;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] n_in  = '0;
  logic [23:0] d_in  = '0;

  logic        busy1, done1, err1;
  logic [23:0] q1, a1, b1;
  logic [47:0] p1;

  logic        busy3, done3, err3;
  logic [23:0] q3, a3, b3;
  logic [47:0] p3;
  logic [47:0] m3 [3];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  goldschmidt_ctrl #(.MUL_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .start(start),
    .n_in(n_in), .d_in(d_in),
    .busy(busy1), .done(done1), .q(q1), .err(err1),
    .mul_a(a1), .mul_b(b1), .mul_p(p1)
  );

  goldschmidt_ctrl #(.MUL_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .start(start),
    .n_in(n_in), .d_in(d_in),
    .busy(busy3), .done(done3), .q(q3), .err(err3),
    .mul_a(a3), .mul_b(b3), .mul_p(p3)
  );

  always @(posedge clock) begin
    p1    <= {24'b0, a1} * {24'b0, b1};
    m3[0] <= {24'b0, a3} * {24'b0, b3};
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign p3 = m3[2];

  task automatic check(input string tag,
                       input logic [47:0] got,
                       input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          dc1, dc3, nd1, nd3;
  logic        bz1, re1, re3;
  logic [23:0] rq1, rq3;
  int          diff;

  task automatic run_op(input logic [23:0] n,
                        input logic [23:0] d,
                        input int s1, input int s2);
    @(negedge clock);
    n_in = n;
    d_in = d;
    start = 1'b1;
    dc1 = -1; dc3 = -1; nd1 = 0; nd3 = 0; bz1 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      start = (k == s1) || (k == s2);
      if (k == 1) bz1 = busy1;
      if (done1) begin
        if (nd1 == 0) begin
          dc1 = k; rq1 = q1; re1 = err1;
        end
        nd1++;
      end
      if (done3) begin
        if (nd3 == 0) begin
          dc3 = k; rq3 = q3; re3 = err3;
        end
        nd3++;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int nd;
    repeat (3) @(negedge clock);
    check("rst_busy", 48'(busy1), 48'd0);
    check("rst_done", 48'(done1), 48'd0);
    check("rst_q",    48'(q1),    48'd0);
    check("rst_err",  48'(err1),  48'd0);
    check("rst_a",    48'(a1),    48'd0);
    check("rst_b",    48'(b1),    48'd0);
    check("rst_busy3", 48'(busy3), 48'd0);
    reset = 1'b0;

    run_op(24'h400000, 24'h400000, -1, -1);
    check("s1_dc1",  48'(dc1), 48'd16);
    check("s1_dc3",  48'(dc3), 48'd26);
    check("s1_nd1",  48'(nd1), 48'd1);
    check("s1_nd3",  48'(nd3), 48'd1);
    check("s1_q1",   48'(rq1), 48'(QA));
    check("s1_q3",   48'(rq3), 48'(QA));
    check("s1_err1", 48'(re1), 48'd0);
    check("s1_err3", 48'(re3), 48'd0);
    check("s1_busy", 48'(bz1), 48'd1);
    check("s1_hold", 48'(q1),  48'(QA));
    check("s1_a1",   48'(a1),  48'h7FFF80);
    check("s1_b1",   48'(b1),  48'h800080);
    check("s1_a3",   48'(a3),  48'h7FFF80);

    run_op(24'h600000, 24'h200000, -1, -1);
    check("e1_dc1",  48'(dc1), 48'd1);
    check("e1_dc3",  48'(dc3), 48'd1);
    check("e1_q1",   48'(rq1), 48'hFFFFFF);
    check("e1_err1", 48'(re1), 48'd1);
    check("e1_busy", 48'(bz1), 48'd0);
    check("e1_a1",   48'(a1),  48'h7FFF80);
    check("e1_b1",   48'(b1),  48'h800080);
    check("e1_b3",   48'(b3),  48'h800080);

    run_op(24'h900000, 24'h400000, -1, -1);
    check("e2_dc1",  48'(dc1), 48'd1);
    check("e2_q1",   48'(rq1), 48'hFFFFFF);
    check("e2_err1", 48'(re1), 48'd1);
    check("e2_err3", 48'(re3), 48'd1);
    check("e2_hold", 48'(err1), 48'd1);
    check("e2_a1",   48'(a1),  48'h7FFF80);

    run_op(24'h400000, 24'h7FFFFF, -1, -1);
    check("s2_q1", 48'(rq1 == 24'h400000 || rq1 == 24'h400001), 48'd1);
    check("s2_q3", 48'(rq3 == 24'h400000 || rq3 == 24'h400001), 48'd1);
    check("s2_err1", 48'(re1), 48'd0);
    check("s2_dc1",  48'(dc1), 48'd16);

    run_op(24'h600000, 24'h600000, 3, 10);
    check("s4_nd1", 48'(nd1), 48'd1);
    check("s4_dc1", 48'(dc1), 48'd16);
    check("s4_nd3", 48'(nd3), 48'd1);
    check("s4_dc3", 48'(dc3), 48'd26);
    diff = int'(rq1) - 32'h800000;
    check("s4_q1_ulp", 48'(diff >= -1 && diff <= 1), 48'd1);
    diff = int'(rq3) - 32'h800000;
    check("s4_q3_ulp", 48'(diff >= -1 && diff <= 1), 48'd1);

    @(negedge clock);
    n_in = 24'h400000;
    d_in = 24'h400000;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    check("r_busy1", 48'(busy1), 48'd0);
    check("r_q1",    48'(q1),    48'd0);
    check("r_done1", 48'(done1), 48'd0);
    check("r_a1",    48'(a1),    48'd0);
    check("r_busy3", 48'(busy3), 48'd0);
    check("r_q3",    48'(q3),    48'd0);
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (done1 || done3) nd++;
    end
    check("r_nodone", 48'(nd), 48'd0);

    run_op(24'h400000, 24'h400000, -1, -1);
    check("r2_dc1", 48'(dc1), 48'd16);
    check("r2_dc3", 48'(dc3), 48'd26);
    check("r2_q1",  48'(rq1), 48'(QA));
    check("r2_q3",  48'(rq3), 48'(QA));
    check("r2_err", 48'(re1), 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
